ras_ckpt_stack: RTL and testbench

Parametrised return-address stack with multi-checkpoint recovery. Sits in fetch beside the BTB. Predicts return targets from a circular LIFO and keeps up to CKPT in-order checkpoints of stack state, one per speculative branch. Any in-flight branch that mispredicts restores its checkpoint in one cycle, instead of relying on a single decode-stage checkpoint.

---
 rtl/ras_pkg.sv | 22 ++
 rtl/ras_ckpt_queue.sv | 87 ++++++++
 rtl/ras_ckpt_stack_chk.sv | 21 ++
 rtl/ras_ckpt_stack.sv | 184 ++++++++++++++++++
 tb/tb_ras_ckpt_stack.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ras_pkg.sv
// Shared defaults, widths and checkpoint record for the return-address stack.
// RAS_TOP_REPAIR_EN adds the post-update top-of-stack entry to each checkpoint.
package ras_pkg;

  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CKPT_DEF  = 8;

  localparam int unsigned TOS_W = $clog2(DEPTH_DEF);
  localparam int unsigned CNT_W = $clog2(DEPTH_DEF) + 1;
  localparam int unsigned TAG_W = $clog2(CKPT_DEF);

  // Checkpoint record at the default geometry.
  typedef struct packed {
    logic [TOS_W-1:0]    tos;
    logic [CNT_W-1:0]    count;
`ifdef RAS_TOP_REPAIR_EN
    logic [PC_W_DEF-1:0] top;
`endif
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_queue.sv
// In-order checkpoint ring: slot storage, head/tail/occupancy, full flag and
// tail rollback on recovery. The payload is opaque to this block.
module ras_ckpt_queue
  import ras_pkg::*;
#(
  parameter int unsigned CKPT = CKPT_DEF,
  parameter int unsigned W    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    alloc_i,
  input  logic [W-1:0]            alloc_data_i,
  input  logic                    release_i,
  input  logic                    recover_i,
  input  logic [$clog2(CKPT)-1:0] recover_tag_i,
  output logic [W-1:0]            recover_data_o,
  output logic [$clog2(CKPT)-1:0] tail_o,
  output logic [$clog2(CKPT)-1:0] head_o,
  output logic                    full_o
);

  localparam int unsigned TW = $clog2(CKPT);
  localparam logic [TW:0]   OCC_FULL = (TW+1)'(CKPT);
  localparam logic [TW-1:0] PTR_ONE  = TW'(1);

  logic [W-1:0]  slot_q [CKPT];
  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [TW:0]   occ_q, occ_d;
  logic          full_s, rel_s, alloc_s;

  assign full_s         = (occ_q == OCC_FULL);
  assign recover_data_o = slot_q[recover_tag_i];
  assign tail_o         = tail_q;
  assign head_o         = head_q;
  assign full_o         = full_s;

  // Pointer and occupancy next state; recovery recomputes occupancy from the
  // rolled-back tail so it can never read as full.
  always_comb begin
    rel_s   = release_i && (occ_q != {(TW+1){1'b0}});
    alloc_s = alloc_i && !full_s && !flush_i && !recover_i;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    if (flush_i) begin
      head_d = {TW{1'b0}};
      tail_d = {TW{1'b0}};
      occ_d  = {(TW+1){1'b0}};
    end else begin
      if (rel_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (recover_i) begin
        tail_d = recover_tag_i;
        occ_d  = {1'b0, recover_tag_i - head_d};
      end else begin
        tail_d = alloc_s ? (tail_q + PTR_ONE) : tail_q;
        occ_d  = occ_q + {{TW{1'b0}}, alloc_s} - {{TW{1'b0}}, rel_s};
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= {TW{1'b0}};
      tail_q <= {TW{1'b0}};
      occ_q  <= {(TW+1){1'b0}};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Slot storage; only outstanding slots are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      slot_q[tail_q] <= alloc_data_i;
    end
  end

endmodule

// File: rtl/ras_ckpt_stack_chk.sv
// Protocol checker: a same-cycle release and recovery must not target the head.
module ras_ckpt_stack_chk #(
  parameter int unsigned TAG_W = 3
) (
  input logic             clk,
  input logic             reset,
  input logic             recover_i,
  input logic             release_i,
  input logic [TAG_W-1:0] recover_tag_i,
  input logic [TAG_W-1:0] head_i
);

  // Illegal release/recover collision on the head checkpoint.
  always @(posedge clk) begin
    if (!reset && recover_i && release_i) begin
      assert (recover_tag_i != head_i)
        else $error("ras_ckpt_stack: recover_tag_i equals head while release_i is set");
    end
  end

endmodule

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with in-order multi-checkpoint recovery.
// RAS_TOP_REPAIR_EN: checkpoints also restore the top entry on recovery.
module ras_ckpt_stack
  import ras_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CKPT  = CKPT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [PC_W-1:0]         push_addr_i,
  input  logic                    ckpt_i,
  output logic [$clog2(CKPT)-1:0] ckpt_tag_o,
  output logic                    ckpt_full_o,
  input  logic                    release_i,
  input  logic                    recover_i,
  input  logic [$clog2(CKPT)-1:0] recover_tag_i,
  input  logic                    flush_i,
  output logic [PC_W-1:0]         top_addr_o,
  output logic                    top_valid_o
);

  localparam int unsigned SW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(CKPT);
  localparam logic [SW-1:0] TOS_ONE = SW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Checkpoint record sized for this instance's geometry.
  typedef struct packed {
    logic [SW-1:0]   tos;
    logic [CW-1:0]   count;
`ifdef RAS_TOP_REPAIR_EN
    logic [PC_W-1:0] top;
`endif
  } ckpt_t;

  logic [PC_W-1:0] stack_q [DEPTH];
  logic [SW-1:0]   tos_q, tos_d, upd_tos_s;
  logic [CW-1:0]   count_q, count_d, upd_cnt_s;
  logic            do_push_s, do_pop_s, alloc_s;
  logic            stk_we_s, upd_we_s;
  logic [SW-1:0]   stk_waddr_s, upd_waddr_s;
  logic [PC_W-1:0] stk_wdata_s;
  logic [TW-1:0]   head_s;
  ckpt_t           ck_wr_s, ck_rd_s;
`ifdef RAS_TOP_REPAIR_EN
  logic [PC_W-1:0] upd_top_s;
`endif

  // Speculative push/pop result, also what a same-cycle checkpoint captures.
  always_comb begin
    do_push_s   = push_i && !stall_i;
    do_pop_s    = pop_i && !stall_i;
    upd_tos_s   = tos_q;
    upd_cnt_s   = count_q;
    upd_we_s    = 1'b0;
    upd_waddr_s = tos_q;
`ifdef RAS_TOP_REPAIR_EN
    upd_top_s   = stack_q[tos_q];
`endif
    case ({do_push_s, do_pop_s})
      2'b11: begin
        upd_we_s = 1'b1;
`ifdef RAS_TOP_REPAIR_EN
        upd_top_s = push_addr_i;
`endif
      end
      2'b10: begin
        upd_tos_s   = tos_q + TOS_ONE;
        upd_cnt_s   = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);
        upd_we_s    = 1'b1;
        upd_waddr_s = tos_q + TOS_ONE;
`ifdef RAS_TOP_REPAIR_EN
        upd_top_s = push_addr_i;
`endif
      end
      2'b01: begin
        upd_tos_s = tos_q - TOS_ONE;
        upd_cnt_s = (count_q == {CW{1'b0}}) ? count_q : (count_q - CNT_ONE);
`ifdef RAS_TOP_REPAIR_EN
        upd_top_s = stack_q[tos_q - TOS_ONE];
`endif
      end
      default: begin
        upd_we_s = 1'b0;
      end
    endcase
    ck_wr_s.tos   = upd_tos_s;
    ck_wr_s.count = upd_cnt_s;
`ifdef RAS_TOP_REPAIR_EN
    ck_wr_s.top   = upd_top_s;
`endif
  end

  // Priority: flush over recovery over the speculative update.
  always_comb begin
    alloc_s     = ckpt_i && !stall_i && !recover_i && !flush_i;
    tos_d       = tos_q;
    count_d     = count_q;
    stk_we_s    = 1'b0;
    stk_waddr_s = upd_waddr_s;
    stk_wdata_s = push_addr_i;
    if (flush_i) begin
      tos_d    = {SW{1'b0}};
      count_d  = {CW{1'b0}};
      stk_we_s = 1'b0;
    end else if (recover_i) begin
      tos_d   = ck_rd_s.tos;
      count_d = ck_rd_s.count;
`ifdef RAS_TOP_REPAIR_EN
      stk_we_s    = 1'b1;
      stk_waddr_s = ck_rd_s.tos;
      stk_wdata_s = ck_rd_s.top;
`else
      stk_we_s    = 1'b0;
`endif
    end else begin
      tos_d    = upd_tos_s;
      count_d  = upd_cnt_s;
      stk_we_s = upd_we_s;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q   <= {SW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  // Stack storage; reset clears contents, flush deliberately does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {PC_W{1'b0}};
      end
    end else if (stk_we_s) begin
      stack_q[stk_waddr_s] <= stk_wdata_s;
    end
  end

  ras_ckpt_queue #(
    .CKPT (CKPT),
    .W    ($bits(ckpt_t))
  ) u_queue (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .alloc_i        (alloc_s),
    .alloc_data_i   (ck_wr_s),
    .release_i      (release_i),
    .recover_i      (recover_i),
    .recover_tag_i  (recover_tag_i),
    .recover_data_o (ck_rd_s),
    .tail_o         (ckpt_tag_o),
    .head_o         (head_s),
    .full_o         (ckpt_full_o)
  );

  ras_ckpt_stack_chk #(
    .TAG_W (TW)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .recover_i     (recover_i),
    .release_i     (release_i),
    .recover_tag_i (recover_tag_i),
    .head_i        (head_s)
  );

  assign top_addr_o  = stack_q[tos_q];
  assign top_valid_o = (count_q != {CW{1'b0}});

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Self-checking bench for ras_ckpt_stack: directed plan steps then random
// traffic against a queue-based reference model.
module tb_ras_ckpt_stack;

  localparam int D = 16;
  localparam int C = 8;

  logic        clk = 1'b0;
  logic        reset, stall_i, push_i, pop_i, ckpt_i, release_i, recover_i, flush_i;
  logic [31:0] push_addr_i;
  logic [2:0]  recover_tag_i;
  logic [2:0]  ckpt_tag_o;
  logic        ckpt_full_o, top_valid_o;
  logic [31:0] top_addr_o;

  ras_ckpt_stack dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .push_addr_i   (push_addr_i),
    .ckpt_i        (ckpt_i),
    .ckpt_tag_o    (ckpt_tag_o),
    .ckpt_full_o   (ckpt_full_o),
    .release_i     (release_i),
    .recover_i     (recover_i),
    .recover_tag_i (recover_tag_i),
    .flush_i       (flush_i),
    .top_addr_o    (top_addr_o),
    .top_valid_o   (top_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tos;
    int          cnt;
    logic [31:0] top;
    int          tag;
  } ck_t;

  ck_t         ckq[$];
  logic [31:0] m_stack [D];
  int          m_tos, m_cnt, m_tag;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: checkpoints are a list of snapshots, recovery truncates it.
  task automatic model_step();
    int sz0;
    int idx;
    sz0 = ckq.size();
    if (reset) begin
      for (int i = 0; i < D; i++) m_stack[i] = 32'd0;
      m_tos = 0; m_cnt = 0; m_tag = 0;
      ckq.delete();
    end else if (flush_i) begin
      m_tos = 0; m_cnt = 0; m_tag = 0;
      ckq.delete();
    end else begin
      if (recover_i) begin
        idx = -1;
        foreach (ckq[i]) if (ckq[i].tag == int'(recover_tag_i)) idx = i;
        if (idx >= 0) begin
          m_tos = ckq[idx].tos;
          m_cnt = ckq[idx].cnt;
`ifdef RAS_TOP_REPAIR_EN
          m_stack[m_tos] = ckq[idx].top;
`endif
          while (ckq.size() > idx) void'(ckq.pop_back());
        end
        m_tag = int'(recover_tag_i);
      end else if (!stall_i) begin
        if (push_i && pop_i) begin
          m_stack[m_tos] = push_addr_i;
        end else if (push_i) begin
          m_tos = (m_tos + 1) % D;
          m_stack[m_tos] = push_addr_i;
          m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
        end else if (pop_i) begin
          m_tos = (m_tos + D - 1) % D;
          m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end
        if (ckpt_i && sz0 < C) begin
          ckq.push_back('{m_tos, m_cnt, m_stack[m_tos], m_tag});
          m_tag = (m_tag + 1) % C;
        end
      end
      if (release_i && sz0 > 0) void'(ckq.pop_front());
    end
  endtask

  task automatic cyc(input logic ps, input logic pp, input logic [31:0] a, input logic ck,
                     input logic rl, input logic rc, input logic [2:0] tg, input logic fl,
                     input logic st);
    push_i = ps; pop_i = pp; push_addr_i = a; ckpt_i = ck; release_i = rl;
    recover_i = rc; recover_tag_i = tg; flush_i = fl; stall_i = st;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("top_addr", top_addr_o, m_stack[m_tos]);
    chk("top_valid", {31'd0, top_valid_o}, {31'd0, (m_cnt != 0)});
    chk("ckpt_tag", {29'd0, ckpt_tag_o}, m_tag);
    chk("ckpt_full", {31'd0, ckpt_full_o}, {31'd0, (ckq.size() == C)});
  endtask

  task automatic nop();                   cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input logic [31:0] a); cyc(1, 0, a, 0, 0, 0, 0, 0, 0); endtask
  task automatic pop();                   cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ckpt();                  cyc(0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic rel();                   cyc(0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic rec(input logic [2:0] t); cyc(0, 0, 0, 0, 0, 1, t, 0, 0); endtask
  task automatic flush();                 cyc(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask

  logic        r_ps, r_pp, r_ck, r_rl, r_rc, r_fl, r_st;
  logic [31:0] r_a;
  logic [2:0]  r_tg;
  int          r_idx;

  initial begin
    reset = 1'b1;
    nop();
    nop();
    chk("rst_top_addr", top_addr_o, 32'h0);
    chk("rst_top_valid", {31'd0, top_valid_o}, 32'd0);
    chk("rst_ckpt_tag", {29'd0, ckpt_tag_o}, 32'd0);
    chk("rst_ckpt_full", {31'd0, ckpt_full_o}, 32'd0);
    reset = 1'b0;

    push(32'h100); push(32'h200); push(32'h300);
    chk("push3_top", top_addr_o, 32'h300);
    pop();
    chk("pop_top", top_addr_o, 32'h200);
    chk("pop_valid", {31'd0, top_valid_o}, 32'd1);

    flush();
    for (int i = 0; i < 17; i++) push(32'h1000 + i);
    chk("ovf_top", top_addr_o, 32'h1010);
    for (int i = 0; i < 16; i++) pop();
    chk("drain_valid", {31'd0, top_valid_o}, 32'd0);
    pop();
    chk("underflow_valid", {31'd0, top_valid_o}, 32'd0);

    flush();
    push(32'hA0);
    chk("alloc_tag0", {29'd0, ckpt_tag_o}, 32'd0);
    ckpt();
    push(32'hB0); push(32'hC0);
    rec(3'd0);
    chk("rec_top", top_addr_o, 32'hA0);
    chk("rec_tag", {29'd0, ckpt_tag_o}, 32'd0);

    flush();
    for (int i = 0; i < 8; i++) ckpt();
    chk("full8", {31'd0, ckpt_full_o}, 32'd1);
    ckpt();
    chk("drop9_tag", {29'd0, ckpt_tag_o}, 32'd0);
    rel();
    chk("rel_full", {31'd0, ckpt_full_o}, 32'd0);

    flush();
    push(32'hA0); ckpt(); pop(); push(32'hEE);
    rec(3'd0);
`ifdef RAS_TOP_REPAIR_EN
    chk("repair_top", top_addr_o, 32'hA0);
`else
    chk("repair_top", top_addr_o, 32'hEE);
`endif

    flush();
    push(32'h11); ckpt(); push(32'h22); ckpt(); push(32'h33);
    cyc(1, 0, 32'h55, 1, 0, 1, 3'd1, 0, 0);
    chk("recprio_top", top_addr_o, 32'h22);
    chk("recprio_tag", {29'd0, ckpt_tag_o}, 32'd1);
    flush();
    chk("flush_valid", {31'd0, top_valid_o}, 32'd0);
    chk("flush_tag", {29'd0, ckpt_tag_o}, 32'd0);

    push(32'h77); ckpt(); push(32'h88);
    reset = 1'b1;
    nop();
    reset = 1'b0;
    chk("midrst_top", top_addr_o, 32'h0);
    chk("midrst_tag", {29'd0, ckpt_tag_o}, 32'd0);

    for (int n = 0; n < 800; n++) begin
      r_ps = ($urandom_range(0, 2) == 0);
      r_pp = ($urandom_range(0, 2) == 0);
      r_a  = $urandom;
      r_ck = ($urandom_range(0, 3) == 0);
      r_rl = ($urandom_range(0, 4) == 0);
      r_st = ($urandom_range(0, 6) == 0);
      r_fl = ($urandom_range(0, 59) == 0);
      r_rc = 1'b0;
      r_tg = 3'd0;
      if ($urandom_range(0, 14) == 0 && ckq.size() > 0) begin
        r_idx = $urandom_range(0, ckq.size() - 1);
        r_rc  = 1'b1;
        r_tg  = 3'(ckq[r_idx].tag);
        if (r_idx == 0) r_rl = 1'b0;
      end
      cyc(r_ps, r_pp, r_a, r_ck, r_rl, r_rc, r_tg, r_fl, r_st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
